// File: rtl/iir_frame_host.sv
// Frame buffer and memory-style responder for an IIR filter core: collects a
// sample frame, runs the filter over it out of reset, then streams its results.
module iir_frame_host #(
  parameter int DEPTH = 64,
  parameter int AW    = 6
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic signed [15:0] in_data,
  input  logic               in_last,
  output logic               out_valid,
  input  logic               out_ready,
  output logic signed [15:0] out_data,
  output logic               out_last,
  output logic               filt_rst,
  input  logic               filt_load,
  input  logic [19:0]        filt_raddr,
  output logic signed [15:0] filt_din,
  input  logic               filt_wen,
  input  logic [19:0]        filt_waddr,
  input  logic signed [15:0] filt_yn,
  output logic               filt_done,
  input  logic               filt_finish,
  output logic               busy,
  output logic               overrun_err
);

  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  typedef enum logic [1:0] {FILL, RUN, DRAIN} state_t;

  state_t            state, state_nxt;
  logic [CW-1:0]     count, len;
  logic [AW-1:0]     rd_ptr;
  logic signed [15:0] ibuf [DEPTH];
  logic signed [15:0] obuf [DEPTH];

  logic [CW-1:0] len_m1;
  logic [19:0]   len_ext, len_m1_ext;
  logic          accept, finish_hs, out_hs;

  // Filter addresses are compared at full width so high address bits never alias.
  assign len_m1     = len - CW'(1);
  assign len_ext    = {{(20-CW){1'b0}}, len};
  assign len_m1_ext = {{(20-CW){1'b0}}, len_m1};
  assign finish_hs  = (state == RUN) && filt_finish && filt_done;
  assign out_hs     = out_valid && out_ready;

  // NOTE: every signal driven in always_comb gets a default first, so no path
  // can leave it unassigned and infer a latch.
  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    out_last  = 1'b0;
    out_data  = '0;
    case (state)
      FILL: begin
        in_ready = (count < DEPTH_C);
        if (in_valid && in_ready && in_last) state_nxt = RUN;
        else if (count == DEPTH_C)           state_nxt = RUN;
      end
      RUN: begin
        if (finish_hs) state_nxt = DRAIN;
      end
      DRAIN: begin
        out_valid = 1'b1;
        out_data  = obuf[rd_ptr];
        out_last  = ({1'b0, rd_ptr} == len_m1);
        if (out_ready && out_last) state_nxt = FILL;
      end
      default: state_nxt = FILL;
    endcase
  end

  assign accept   = (state == FILL) && in_valid && in_ready;
  assign busy     = (state == RUN) || (state == DRAIN);
  assign filt_din = (filt_load && (filt_raddr < len_ext)) ? ibuf[filt_raddr[AW-1:0]] : '0;

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= FILL;
      count       <= '0;
      len         <= '0;
      rd_ptr      <= '0;
      filt_rst    <= 1'b1;
      filt_done   <= 1'b0;
      overrun_err <= 1'b0;
    end else begin
      state <= state_nxt;
      case (state)
        FILL: begin
          filt_rst  <= 1'b1;
          filt_done <= 1'b0;
          if (accept) begin
            count <= count + CW'(1);
            if (in_last) len <= count + CW'(1);
          end else if (count == DEPTH_C) begin
            len         <= DEPTH_C;
            overrun_err <= 1'b1;
          end
        end
        RUN: begin
          if (finish_hs) begin
            filt_rst  <= 1'b1;
            filt_done <= 1'b0;
          end else begin
            filt_rst <= 1'b0;
            if (!filt_rst && (filt_raddr == len_m1_ext)) filt_done <= 1'b1;
          end
        end
        DRAIN: begin
          filt_rst  <= 1'b1;
          filt_done <= 1'b0;
          if (out_hs) begin
            if (out_last) begin
              rd_ptr <= '0;
              count  <= '0;
            end else begin
              rd_ptr <= rd_ptr + AW'(1);
            end
          end
        end
        default: ;
      endcase
    end
  end

  // NOTE: buffer storage has no reset; every word read is written earlier in
  // the same frame, and leaving memories unreset lets them map onto RAM.
  always_ff @(posedge clk) begin
    if (accept) ibuf[count[AW-1:0]] <= in_data;
    if ((state == RUN) && filt_wen && (filt_waddr < len_ext))
      obuf[filt_waddr[AW-1:0]] <= filt_yn;
  end

endmodule

// File: tb/tb_iir_frame_host.sv
// Self-checking bench for iir_frame_host: a behavioural filter model drives the
// memory port, and a frame-level reference predicts the result stream.
module tb_iir_frame_host;

  localparam int DEPTH = 8;
  localparam int AW    = 3;

  logic               clk, rst;
  logic               in_valid, in_ready, in_last;
  logic signed [15:0] in_data;
  logic               out_valid, out_ready, out_last;
  logic signed [15:0] out_data;
  logic               filt_rst, filt_load, filt_wen, filt_done, filt_finish;
  logic [19:0]        filt_raddr, filt_waddr;
  logic signed [15:0] filt_din, filt_yn;
  logic               busy, overrun_err;

  iir_frame_host #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
    .filt_rst(filt_rst), .filt_load(filt_load), .filt_raddr(filt_raddr), .filt_din(filt_din),
    .filt_wen(filt_wen), .filt_waddr(filt_waddr), .filt_yn(filt_yn), .filt_done(filt_done),
    .filt_finish(filt_finish), .busy(busy), .overrun_err(overrun_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  logic signed [15:0] cur_frame[$];
  logic signed [15:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic filt_idle();
    filt_load = 1'b0; filt_wen = 1'b0; filt_finish = 1'b0;
    filt_raddr = '0; filt_waddr = '0; filt_yn = '0;
  endtask

  // Reference: result k is 3*k, plus input sample k when the filter adds its input.
  task automatic build_exp(input bit mode);
    exp_q = {};
    foreach (cur_frame[k]) exp_q.push_back(16'(mode ? cur_frame[k] + 3*k : 3*k));
  endtask

  task automatic send_frame(input bit use_last, input bit gaps, input int max_wait,
                            output int accepted);
    accepted = 0;
    for (int i = 0; i < cur_frame.size(); i++) begin
      if (gaps) begin
        in_valid = 1'b0;
        repeat ($urandom_range(0, 2)) step();
      end
      in_valid = 1'b1;
      in_data  = cur_frame[i];
      in_last  = use_last && (i == cur_frame.size() - 1);
      for (int w = 0; w < max_wait && !in_ready; w++) step();
      if (!in_ready) break;
      step();
      accepted++;
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  // Filter model: reads address t each cycle, writes result t-1 from the sample
  // it read last cycle, and raises Finish as soon as data_done is seen.
  task automatic run_filter(input bit mode, input int abort_at, input int exp_len,
                            output bit aborted);
    int t;
    bit finished;
    logic signed [15:0] dprev, dexp;
    t = 0; finished = 1'b0; aborted = 1'b0;
    for (int w = 0; w < 20 && filt_rst; w++) step();
    check("filt_release", filt_rst, 1'b0);
    while (!finished && t <= exp_len + 4) begin
      check("filt_done", filt_done, (t == exp_len));
      dprev = '0;
      if (t > 0) begin
        dprev = filt_din;
        dexp  = (t - 1 < exp_len) ? cur_frame[t-1] : 16'sd0;
        check("filt_din", dprev, dexp);
      end
      filt_raddr = 20'(t);
      filt_load  = 1'b1;
      if (t == abort_at) begin
        #1 rst = 1'b1;
        #1;
        check("abort_filt_rst", filt_rst, 1'b1);
        check("abort_busy", busy, 1'b0);
        check("abort_out_valid", out_valid, 1'b0);
        check("abort_in_ready", in_ready, 1'b1);
        filt_idle();
        step();
        rst = 1'b0;
        aborted = 1'b1;
        return;
      end
      filt_wen = (t > 0);
      if (t > 0) begin
        filt_waddr = 20'(t - 1);
        filt_yn    = 16'(mode ? dprev + 3*(t-1) : 3*(t-1));
      end
      filt_finish = filt_done;
      finished    = filt_done;
      step();
      t++;
    end
    filt_idle();
    check("filt_finish_seen", finished, 1'b1);
    check("drain_filt_rst", filt_rst, 1'b1);
    check("drain_filt_done", filt_done, 1'b0);
    check("drain_busy", busy, 1'b1);
  endtask

  task automatic drain(input bit random_ready);
    int idx, cyc;
    bit hs;
    idx = 0; cyc = 0;
    while (idx < exp_q.size() && cyc < 200) begin
      check("out_valid", out_valid, 1'b1);
      check("out_data", out_data, exp_q[idx]);
      check("out_last", out_last, (idx == exp_q.size() - 1));
      out_ready = random_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      @(posedge clk);
      hs = out_ready && out_valid;
      #1;
      if (hs) idx++;
      cyc++;
    end
    out_ready = 1'b0;
    check("drain_count", idx, exp_q.size());
    check("fill_out_valid", out_valid, 1'b0);
    check("fill_busy", busy, 1'b0);
    check("fill_in_ready", in_ready, 1'b1);
  endtask

  task automatic full_frame(input int n, input bit mode);
    int acc;
    bit ab;
    cur_frame = {};
    for (int i = 0; i < n; i++) cur_frame.push_back(16'($urandom));
    send_frame(1'b1, 1'b1, 20, acc);
    check("frame_accepts", acc, n);
    run_filter(mode, -1, n, ab);
    build_exp(mode);
    drain(1'b1);
  endtask

  initial begin
    int acc;
    bit ab;
    rst = 1'b1;
    in_valid = 1'b0; in_last = 1'b0; in_data = '0; out_ready = 1'b0;
    filt_idle();
    repeat (2) step();
    check("rst_filt_rst", filt_rst, 1'b1);
    check("rst_filt_done", filt_done, 1'b0);
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_out_last", out_last, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_overrun", overrun_err, 1'b0);
    check("rst_in_ready", in_ready, 1'b1);
    rst = 1'b0;
    step();

    // Directed frame: results 3*k, release timing and read-port probes.
    cur_frame = {16'sd100, 16'sd200, -16'sd300, 16'sd400};
    send_frame(1'b1, 1'b0, 20, acc);
    check("f1_accepts", acc, 4);
    check("f1_filt_rst_held", filt_rst, 1'b1);
    check("f1_in_ready_run", in_ready, 1'b0);
    check("f1_busy", busy, 1'b1);
    step();
    check("f1_filt_rst_fall", filt_rst, 1'b0);
    filt_raddr = 20'd2; filt_load = 1'b1; #1;
    check("probe_raddr2", filt_din, -16'sd300);
    filt_raddr = 20'd5; #1;
    check("probe_raddr5", filt_din, 16'sd0);
    filt_raddr = 20'h10002; #1;
    check("probe_raddr_hi", filt_din, 16'sd0);
    filt_raddr = 20'd2; filt_load = 1'b0; #1;
    check("probe_noload", filt_din, 16'sd0);
    filt_idle();
    run_filter(1'b0, -1, 4, ab);
    build_exp(1'b0);
    drain(1'b0);
    check("f1_overrun", overrun_err, 1'b0);

    // Overrun: ten samples without in_last, only DEPTH are taken.
    cur_frame = {};
    for (int i = 0; i < 10; i++) cur_frame.push_back(16'($urandom));
    send_frame(1'b0, 1'b0, 0, acc);
    check("ovr_accepts", acc, DEPTH);
    check("ovr_in_ready", in_ready, 1'b0);
    in_valid = 1'b0;
    while (cur_frame.size() > DEPTH) void'(cur_frame.pop_back());
    run_filter(1'b1, -1, DEPTH, ab);
    check("ovr_flag", overrun_err, 1'b1);
    build_exp(1'b1);
    drain(1'b1);

    for (int f = 0; f < 5; f++) full_frame($urandom_range(1, DEPTH), 1'b1);
    check("ovr_sticky", overrun_err, 1'b1);

    // Single-sample frame.
    cur_frame = {-16'sd1};
    send_frame(1'b1, 1'b0, 20, acc);
    check("single_accepts", acc, 1);
    run_filter(1'b1, -1, 1, ab);
    build_exp(1'b1);
    drain(1'b1);

    // Reset pulse while the filter is at raddr 2, then a clean 3-sample frame.
    cur_frame = {};
    for (int i = 0; i < 5; i++) cur_frame.push_back(16'($urandom));
    send_frame(1'b1, 1'b0, 20, acc);
    run_filter(1'b1, 2, 5, ab);
    check("abort_taken", ab, 1'b1);
    check("abort_overrun_clr", overrun_err, 1'b0);
    full_frame(3, 1'b1);
    check("post_abort_overrun", overrun_err, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
